// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between the fetch and LSU masters.
// An owner-ID FIFO tracks granted-but-unanswered transactions so in-order responses return to their issuer.
module mem_port_arbiter #(
  parameter int WORD_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  instr_req_i,
  input  logic [WORD_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [WORD_WIDTH-1:0] instr_rdata_o,

  input  logic                  data_req_i,
  input  logic [WORD_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [WORD_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [WORD_WIDTH-1:0] data_rdata_o,

  output logic                  mem_req_o,
  output logic [WORD_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [WORD_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i,

  output logic                  err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  owner_e                     last_winner_q, last_winner_d;
  owner_e                     locked_owner_q, locked_owner_d;
  logic                       lock_q, lock_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       err_q, err_d;

  owner_e sel;
  owner_e head;
  logic   sel_req;
  logic   not_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A stalled request keeps its owner, otherwise alternate away from the last winner.
  always_comb begin
    sel = OWN_INSTR;
    if (lock_q) begin
      sel = locked_owner_q;
    end else if (instr_req_i && !data_req_i) begin
      sel = OWN_INSTR;
    end else if (data_req_i && !instr_req_i) begin
      sel = OWN_DATA;
    end else if (data_req_i && instr_req_i) begin
      sel = (last_winner_q == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
    end
  end

  assign fifo_empty = (count_q == '0);
  assign not_full   = (count_q < CNT_W'(MAX_OUTSTANDING));
  assign sel_req    = (sel == OWN_DATA) ? data_req_i : instr_req_i;
  assign head       = owner_e'(fifo_q[rd_ptr_q]);

  assign mem_req_o  = sel_req && not_full && !rst;
  assign push       = mem_req_o && mem_gnt_i;
  assign pop        = mem_rvalid_i && !fifo_empty && !rst;

  always_comb begin
    mem_addr_o  = instr_addr_i;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b1111;
    mem_wdata_o = '0;
    if (sel == OWN_DATA) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign instr_gnt_o    = push && (sel == OWN_INSTR);
  assign data_gnt_o     = push && (sel == OWN_DATA);
  assign instr_rvalid_o = pop && (head == OWN_INSTR);
  assign data_rvalid_o  = pop && (head == OWN_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign err_o          = err_q;

  always_comb begin
    last_winner_d  = last_winner_q;
    locked_owner_d = locked_owner_q;
    lock_d         = lock_q;
    fifo_d         = fifo_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    err_d          = err_q;

    if (push) begin
      lock_d           = 1'b0;
      last_winner_d    = sel;
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else if (mem_req_o) begin
      lock_d         = 1'b1;
      locked_owner_d = sel;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A response with nothing outstanding (including leftovers from before a reset) is a protocol error.
    if (mem_rvalid_i && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_winner_q  <= OWN_INSTR;
      locked_owner_q <= OWN_INSTR;
      lock_q         <= 1'b0;
      fifo_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      err_q          <= 1'b0;
    end else begin
      last_winner_q  <= last_winner_d;
      locked_owner_q <= locked_owner_d;
      lock_q         <= lock_d;
      fifo_q         <= fifo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      err_q          <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a queue-based transaction model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_mem_port_arbiter;

  localparam int W    = 32;
  localparam int MAXO = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         instr_req_i = 1'b0;
  logic [W-1:0] instr_addr_i = '0;
  logic         instr_gnt_o, instr_rvalid_o;
  logic [W-1:0] instr_rdata_o;
  logic         data_req_i = 1'b0;
  logic [W-1:0] data_addr_i = '0;
  logic         data_we_i = 1'b0;
  logic [3:0]   data_be_i = '0;
  logic [W-1:0] data_wdata_i = '0;
  logic         data_gnt_o, data_rvalid_o;
  logic [W-1:0] data_rdata_o;
  logic         mem_req_o, mem_we_o;
  logic [W-1:0] mem_addr_o, mem_wdata_o;
  logic [3:0]   mem_be_o;
  logic         mem_gnt_i = 1'b0;
  logic         mem_rvalid_i = 1'b0;
  logic [W-1:0] mem_rdata_i = '0;
  logic         err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_WIDTH(W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: owners of outstanding transactions in a queue, a pending (stalled) owner,
  // and the last granted master. 0 = fetch, 1 = LSU.
  int q[$];
  int lw     = 0;
  int pend   = -1;
  bit err_m  = 1'b0;

  always @(negedge clk) begin : compare
    int own;
    bit ereq, hs, pop;
    int head;
    if (rst) begin
      chk("rst_mem_req", 32'(mem_req_o), 0);
      chk("rst_instr_gnt", 32'(instr_gnt_o), 0);
      chk("rst_data_gnt", 32'(data_gnt_o), 0);
      chk("rst_instr_rvalid", 32'(instr_rvalid_o), 0);
      chk("rst_data_rvalid", 32'(data_rvalid_o), 0);
      chk("rst_err", 32'(err_o), 0);
      q.delete();
      lw    = 0;
      pend  = -1;
      err_m = 1'b0;
    end else begin
      own = -1;
      if (pend >= 0)                       own = pend;
      else if (instr_req_i && !data_req_i) own = 0;
      else if (data_req_i && !instr_req_i) own = 1;
      else if (data_req_i && instr_req_i)  own = 1 - lw;
      ereq = ((own == 0 && instr_req_i) || (own == 1 && data_req_i)) && (q.size() < MAXO);
      hs   = ereq && mem_gnt_i;
      pop  = mem_rvalid_i && (q.size() > 0);
      head = pop ? q[0] : -1;

      chk("m_mem_req", 32'(mem_req_o), 32'(ereq));
      chk("m_instr_gnt", 32'(instr_gnt_o), 32'(hs && own == 0));
      chk("m_data_gnt", 32'(data_gnt_o), 32'(hs && own == 1));
      if (ereq && own == 0) begin
        chk("m_addr_i", mem_addr_o, instr_addr_i);
        chk("m_we_i", 32'(mem_we_o), 0);
        chk("m_be_i", 32'(mem_be_o), 32'hF);
      end
      if (ereq && own == 1) begin
        chk("m_addr_d", mem_addr_o, data_addr_i);
        chk("m_we_d", 32'(mem_we_o), 32'(data_we_i));
        chk("m_be_d", 32'(mem_be_o), 32'(data_be_i));
        chk("m_wdata_d", mem_wdata_o, data_wdata_i);
      end
      chk("m_instr_rvalid", 32'(instr_rvalid_o), 32'(head == 0));
      chk("m_data_rvalid", 32'(data_rvalid_o), 32'(head == 1));
      chk("m_instr_rdata", instr_rdata_o, mem_rdata_i);
      chk("m_data_rdata", data_rdata_o, mem_rdata_i);
      chk("m_err", 32'(err_o), 32'(err_m));

      if (pop) void'(q.pop_front());
      if (hs) begin
        q.push_back(own);
        lw   = own;
        pend = -1;
      end else if (ereq) begin
        pend = own;
      end
      if (mem_rvalid_i && !pop) err_m = 1'b1;
    end
  end

  task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                       input bit dwe, input logic [3:0] dbe, input logic [31:0] dwd,
                       input bit g, input bit rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    instr_req_i  = ir;  instr_addr_i = ia;
    data_req_i   = dr;  data_addr_i  = da;  data_we_i = dwe; data_be_i = dbe; data_wdata_i = dwd;
    mem_gnt_i    = g;   mem_rvalid_i = rv;  mem_rdata_i = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
  endtask

  task automatic reset_dut();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fetch only, immediate grant, response next cycle.
    reset_dut();
    drive(1, 32'h100, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    #2;
    chk("t1_instr_gnt", 32'(instr_gnt_o), 1);
    chk("t1_data_gnt", 32'(data_gnt_o), 0);
    chk("t1_addr", mem_addr_o, 32'h100);
    chk("t1_be", 32'(mem_be_o), 32'hF);
    drive(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'hDEADBEEF);
    #2;
    chk("t1_instr_rvalid", 32'(instr_rvalid_o), 1);
    chk("t1_instr_rdata", instr_rdata_o, 32'hDEADBEEF);
    chk("t1_data_rvalid", 32'(data_rvalid_o), 0);

    // Both masters every cycle: grants alternate starting with the LSU.
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h300 + 32'(k * 4), 1, 32'h400 + 32'(k * 4), 1, 4'hF, 32'(k), 1, k > 0, 32'h1000 + 32'(k));
      #2;
      chk("t2_data_gnt", 32'(data_gnt_o), 32'((k % 2) == 0));
      chk("t2_instr_gnt", 32'(instr_gnt_o), 32'((k % 2) == 1));
      chk("t2_we", 32'(mem_we_o), 32'((k % 2) == 0));
    end

    // Stalled LSU write holds the port even after it won last time.
    reset_dut();
    drive(0, 0, 1, 32'h50, 0, 4'hF, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h55);
    #2 chk("t3_rd_route", 32'(data_rvalid_o), 1);
    for (int k = 0; k < 4; k++) begin
      drive(k > 0, 32'h180, 1, 32'h200, 1, 4'b0011, 32'hCAFE, k == 3, 0, 0);
      #2;
      chk("t3_addr", mem_addr_o, 32'h200);
      chk("t3_we", 32'(mem_we_o), 1);
      chk("t3_be", 32'(mem_be_o), 32'h3);
      chk("t3_instr_gnt", 32'(instr_gnt_o), 0);
      chk("t3_data_gnt", 32'(data_gnt_o), 32'(k == 3));
    end
    drive(1, 32'h180, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    #2 chk("t3_instr_after", 32'(instr_gnt_o), 1);

    // Two outstanding fills the FIFO; responses route in order and issue resumes after first pop.
    reset_dut();
    drive(1, 32'h10, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    #2 chk("t4_g1_instr", 32'(instr_gnt_o), 1);
    drive(0, 0, 1, 32'h20, 0, 4'hF, 0, 1, 0, 0);
    #2 chk("t4_g2_data", 32'(data_gnt_o), 1);
    drive(1, 32'h30, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    #2;
    chk("t4_full_req", 32'(mem_req_o), 0);
    chk("t4_full_gnt", 32'(instr_gnt_o), 0);
    drive(1, 32'h30, 0, 0, 0, 4'h0, 0, 1, 1, 32'h11111111);
    #2;
    chk("t4_r1_req", 32'(mem_req_o), 0);
    chk("t4_r1_instr", 32'(instr_rvalid_o), 1);
    chk("t4_r1_data", 32'(data_rvalid_o), 0);
    chk("t4_r1_rdata", instr_rdata_o, 32'h11111111);
    drive(1, 32'h30, 0, 0, 0, 4'h0, 0, 1, 1, 32'h22222222);
    #2;
    chk("t4_resume_req", 32'(mem_req_o), 1);
    chk("t4_resume_gnt", 32'(instr_gnt_o), 1);
    chk("t4_r2_data", 32'(data_rvalid_o), 1);
    chk("t4_r2_instr", 32'(instr_rvalid_o), 0);
    chk("t4_r2_rdata", data_rdata_o, 32'h22222222);
    drive(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h33333333);
    #2 chk("t4_r3_instr", 32'(instr_rvalid_o), 1);

    // Spurious response sets a sticky error.
    reset_dut();
    drive(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'hBAD);
    #2;
    chk("t5_instr_rvalid", 32'(instr_rvalid_o), 0);
    chk("t5_data_rvalid", 32'(data_rvalid_o), 0);
    idle();
    #2 chk("t5_err_set", 32'(err_o), 1);
    repeat (10) idle();
    #2 chk("t5_err_sticky", 32'(err_o), 1);

    // Reset with two outstanding; a late response afterwards counts as spurious.
    reset_dut();
    drive(1, 32'h40, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    drive(0, 0, 1, 32'h44, 0, 4'hF, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h77);
    #1 chk("t6_pre_rvalid", 32'(instr_rvalid_o), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_rvalid", 32'(instr_rvalid_o), 0);
    chk("t6_async_req", 32'(mem_req_o), 0);
    drive(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h88);
    rst = 1'b0;
    #2;
    chk("t6_late_instr", 32'(instr_rvalid_o), 0);
    chk("t6_late_data", 32'(data_rvalid_o), 0);
    idle();
    #2 chk("t6_err", 32'(err_o), 1);

    repeat (3) idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port (req/gnt/rvalid protocol, in-order responses) between the instruction-fetch master and the load/store data master.
- Sits between core and a unified memory, driving the core's instruction and data interfaces from a single memory bus.
- Provides round-robin arbitration with request locking and an outstanding-transaction FIFO that routes each response to its owner.

Parameters:
- WORD_WIDTH, 32, address/data width.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (power of two, ≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instr_req_i  in  1  fetch request
- instr_addr_i  in  WORD_WIDTH  fetch address
- instr_gnt_o  out  1  fetch request accepted
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  WORD_WIDTH  fetch response data
- data_req_i  in  1  LSU request
- data_addr_i  in  WORD_WIDTH  LSU address
- data_we_i  in  1  LSU write enable
- data_be_i  in  4  LSU byte enables
- data_wdata_i  in  WORD_WIDTH  LSU write data
- data_gnt_o  out  1  LSU request accepted
- data_rvalid_o  out  1  LSU response valid
- data_rdata_o  out  WORD_WIDTH  LSU response data
- mem_req_o  out  1  memory request
- mem_addr_o  out  WORD_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_wdata_o  out  WORD_WIDTH  memory write data
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  WORD_WIDTH  memory response data
- err_o  out  1  sticky: response arrived with no outstanding transaction

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: last_winner=INSTR, lock=0, FIFO empty (count=0), err_o=0.
  - All gnt/rvalid outputs and mem_req_o are 0 while rst=1.
  - mem_req_o is also 0 in the first cycle after release unless a master requests.
- Arbitration (combinational, per cycle):
  - If lock=1, select locked_owner.
  - Else if exactly one master requests, select it.
  - Else if both request, select the master that is not last_winner.
- Issue:
  - mem_req_o = selected master's req AND count<MAX_OUTSTANDING.
  - mem_addr/we/be/wdata are muxed from the selected master.
  - When the fetch master is selected, mem_we_o=0 and mem_be_o=4'b1111.
- Grant:
  - The selected master's gnt_o equals mem_gnt_i AND mem_req_o, in the same cycle, zero latency.
  - The other master's gnt_o is 0.
- Lock:
  - If mem_req_o=1 and mem_gnt_i=0, set lock=1 and locked_owner=selected.
  - Clear lock on the cycle the handshake completes.
  - Ownership therefore cannot change while a request is pending. Masters must hold their request until gnt; dropping one is a protocol violation and its behaviour is undefined.
- On handshake (mem_req_o & mem_gnt_i): push the owner ID into the FIFO and set last_winner to the owner.
- Full:
  - At count==MAX_OUTSTANDING, mem_req_o=0 even if mem_rvalid_i=1 in that cycle.
  - No push occurs in a full cycle; a pop frees a slot for the next cycle.
- Response routing:
  - On mem_rvalid_i with count>0, pop the head ID.
  - Assert only that master's rvalid_o in the same cycle; both rdata_o are driven from mem_rdata_i.
  - The other rvalid_o is 0.
- Simultaneous push and pop (count<MAX): count is unchanged, and the FIFO pointers both advance, wrapping modulo MAX_OUTSTANDING.
- Spurious response (mem_rvalid_i with count==0): no rvalid_o is asserted, err_o is set to 1, and it stays 1 until reset.
- Reset mid-operation: FIFO, lock and state are cleared immediately. Responses to pre-reset transactions that arrive afterwards are treated as spurious.
- Memory is assumed to return responses in issue order, no earlier than the cycle after gnt.

Test Plan:
- Fetch only, addr 0x100, mem_gnt_i=1 immediately, rvalid one cycle later with 0xDEADBEEF → instr_gnt_o=1 in the request cycle; instr_rvalid_o=1 with instr_rdata_o=0xDEADBEEF; data_rvalid_o=0.
- Both request every cycle, mem_gnt_i=1 always (last_winner=INSTR after reset) → grants go DATA, INSTR, DATA, INSTR; mem_we_o=0 on instr cycles.
- Data write, addr 0x200, be=4'b0011, mem_gnt_i held 0 for 3 cycles while instr_req_i rises → mem_addr_o stays 0x200 with we=1 and be=0011 for all 4 cycles; instr_gnt_o=0 until data_gnt_o fires.
- MAX_OUTSTANDING=2, grants to I then D, rvalid withheld → mem_req_o=0 in cycle 3 with a pending request. Responses R1, R2 then route to instr and then data in order, and issue resumes the cycle after the first pop.
- mem_rvalid_i pulsed with no outstanding transaction → both rvalid_o=0 and err_o=1, still 1 after 10 cycles.
- rst asserted with 2 transactions outstanding, then a late rvalid → outputs go 0 asynchronously; after release the late response sets err_o=1 and no rvalid_o is asserted.
